// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: elastic valid/ready register with a 2-entry skid buffer,
// synchronous flush, bubble-gated write enables and a saturating stall counter.
module id_ex_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,

    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic              LinkD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RdD,
    input  logic [REG_W-1:0]  ShamtD,
    input  logic [DATA_W-1:0] ReadData1D,
    input  logic [DATA_W-1:0] ReadData2D,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [DATA_W-1:0] PCPlus4D,

    output logic              out_valid,
    input  logic              out_ready,

    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic              LinkE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [REG_W-1:0]  RsE,
    output logic [REG_W-1:0]  RtE,
    output logic [REG_W-1:0]  RdE,
    output logic [REG_W-1:0]  ShamtE,
    output logic [DATA_W-1:0] ReadData1E,
    output logic [DATA_W-1:0] ReadData2E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [DATA_W-1:0] PCPlus4E,

    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              alu_src;
        logic              reg_dst;
        logic              link;
        logic [ALUC_W-1:0] alu_control;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  shamt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc_plus4;
    } bundle_t;

    bundle_t          in_b;
    bundle_t          m_q, m_d;
    bundle_t          s_q, s_d;
    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] stall_q;

    logic accept;
    logic drain;

    always_comb begin
        in_b             = '0;
        in_b.reg_write   = RegWriteD;
        in_b.mem_to_reg  = MemtoRegD;
        in_b.mem_write   = MemWriteD;
        in_b.alu_src     = ALUSrcD;
        in_b.reg_dst     = RegDstD;
        in_b.link        = LinkD;
        in_b.alu_control = ALUControlD;
        in_b.rs          = RsD;
        in_b.rt          = RtD;
        in_b.rd          = RdD;
        in_b.shamt       = ShamtD;
        in_b.rd1         = ReadData1D;
        in_b.rd2         = ReadData2D;
        in_b.imm         = SignImmD;
        in_b.pc_plus4    = PCPlus4D;
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready = !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = m_valid_q && out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || drain) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = accept;
                if (accept) begin
                    s_d = in_b;
                end
            end else if (accept) begin
                m_d       = in_b;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_d       = in_b;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    // Counts every cycle execute refuses a valid bundle, flush included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (m_valid_q && !out_ready && stall_q != '1) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = m_valid_q;
    assign stall_cnt   = stall_q;

    // Side-effecting controls are forced low in a bubble slot.
    assign RegWriteE   = m_q.reg_write  && m_valid_q;
    assign MemtoRegE   = m_q.mem_to_reg && m_valid_q;
    assign MemWriteE   = m_q.mem_write  && m_valid_q;
    assign LinkE       = m_q.link       && m_valid_q;

    assign ALUSrcE     = m_q.alu_src;
    assign RegDstE     = m_q.reg_dst;
    assign ALUControlE = m_q.alu_control;
    assign RsE         = m_q.rs;
    assign RtE         = m_q.rt;
    assign RdE         = m_q.rd;
    assign ShamtE      = m_q.shamt;
    assign ReadData1E  = m_q.rd1;
    assign ReadData2E  = m_q.rd2;
    assign SignImmE    = m_q.imm;
    assign PCPlus4E    = m_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage: scoreboard of accepted bundles checked on
// every drain, plus point checks for reset, backpressure, flush, gating and saturation.
module tb_id_ex_pipe_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        alusrc;
        logic        regdst;
        logic        link;
        logic [3:0]  aluc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc4;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  stall_cnt;
    bundle_t     d_b;
    bundle_t     e_now;

    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE;
    logic [3:0]  ALUControlE;
    logic [4:0]  RsE, RtE, RdE, ShamtE;
    logic [31:0] ReadData1E, ReadData2E, SignImmE, PCPlus4E;

    bundle_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage #(.DATA_W(32), .REG_W(5), .ALUC_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .RegWriteD(d_b.rw), .MemtoRegD(d_b.m2r), .MemWriteD(d_b.mw),
        .ALUSrcD(d_b.alusrc), .RegDstD(d_b.regdst), .LinkD(d_b.link),
        .ALUControlD(d_b.aluc), .RsD(d_b.rs), .RtD(d_b.rt), .RdD(d_b.rd), .ShamtD(d_b.sh),
        .ReadData1D(d_b.r1), .ReadData2D(d_b.r2), .SignImmD(d_b.imm), .PCPlus4D(d_b.pc4),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .LinkE(LinkE),
        .ALUControlE(ALUControlE), .RsE(RsE), .RtE(RtE), .RdE(RdE), .ShamtE(ShamtE),
        .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
        .stall_cnt(stall_cnt)
    );

    assign e_now = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE, ALUControlE,
                    RsE, RtE, RdE, ShamtE, ReadData1E, ReadData2E, SignImmE, PCPlus4E};

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bundle_t make_bundle(input logic [31:0] pc);
        bundle_t b;
        b.rw     = 1'b1;
        b.m2r    = pc[4];
        b.mw     = pc[3];
        b.alusrc = pc[2];
        b.regdst = pc[6];
        b.link   = pc[5];
        b.aluc   = pc[5:2];
        b.rs     = pc[6:2];
        b.rt     = ~pc[6:2];
        b.rd     = pc[7:3];
        b.sh     = pc[4:0] ^ 5'h15;
        b.r1     = pc * 3 + 1;
        b.r2     = ~pc;
        b.imm    = {pc[15:0], pc[31:16]} ^ 32'h0000_5a5a;
        b.pc4    = pc;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input bit push);
        d_b      = make_bundle(pc);
        in_valid = 1'b1;
        if (push) sb.push_back(d_b);
    endtask

    task automatic randomize_inputs();
        logic [159:0] r;
        r        = {$urandom, $urandom, $urandom, $urandom, $urandom};
        d_b      = r[157:0];
        in_valid = 1'(r[158]);
        out_ready = 1'(r[159]);
        flush    = 1'($urandom_range(0, 1));
    endtask

    // Every drain pops the oldest accepted bundle and compares the whole E-side bundle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check("drain_bundle", e_now, sb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        randomize_inputs();
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            randomize_inputs();
        end
        check("rst_e_bundle", e_now, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt, 0);

        // Streaming: first accept on the first edge after release.
        rst_n     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) begin
            offer(32'(4 * i), 1);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_pc", PCPlus4E, 4 * i);
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("bubble_valid", out_valid, 0);
        check("gate_regwrite", RegWriteE, 0);
        check("gate_link", LinkE, 0);
        check("hold_pc", PCPlus4E, 32);
        check("hold_rd1", ReadData1E, 97);
        check("stream_stall", stall_cnt, 0);
        check("stream_sb_empty", sb.size(), 0);

        // Backpressure: A then B, execute stalls three cycles.
        offer(32'h100, 1);
        step();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_pc", PCPlus4E, 32'h100);
        offer(32'h104, 1);
        out_ready = 1'b0;
        step();
        check("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        step();
        step();
        check("bp_hold_a", PCPlus4E, 32'h100);
        check("bp_hold_valid", out_valid, 1);
        check("bp_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        step();
        check("bp_b_pc", PCPlus4E, 32'h104);
        check("bp_in_ready_high", in_ready, 1);
        check("bp_stall_kept", stall_cnt, 3);
        step();
        check("bp_empty", out_valid, 0);
        check("bp_sb_empty", sb.size(), 0);

        // Flush with both entries full; offered bundle must vanish.
        out_ready = 1'b0;
        offer(32'h200, 1);
        step();
        check("fl_c_valid", out_valid, 1);
        offer(32'h204, 1);
        step();
        check("fl_full_in_ready", in_ready, 0);
        flush = 1'b1;
        offer(32'h2f0, 0);
        sb.delete();
        step();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_regwrite", RegWriteE, 0);
        check("fl_memwrite", MemWriteE, 0);
        check("fl_in_ready", in_ready, 1);

        // Flush while execute consumes M, and an in_ready=1 offer is dropped.
        offer(32'h300, 1);
        step();
        check("fl2_pc", PCPlus4E, 32'h300);
        flush     = 1'b1;
        out_ready = 1'b1;
        offer(32'h3f0, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", out_valid, 0);
        check("fl2_in_ready", in_ready, 1);
        step();
        check("fl2_no_ghost", out_valid, 0);
        check("fl2_sb_empty", sb.size(), 0);
        check("fl_stall5", stall_cnt, 5);

        // Saturation of the 4-bit counter.
        out_ready = 1'b0;
        offer(32'h400, 1);
        step();
        in_valid = 1'b0;
        for (int unsigned i = 0; i < 10; i++) step();
        check("sat_reach", stall_cnt, 15);
        for (int unsigned i = 0; i < 10; i++) step();
        check("sat_hold", stall_cnt, 15);
        flush = 1'b1;
        sb.delete();
        step();
        flush = 1'b0;
        check("sat_after_flush", stall_cnt, 15);
        check("sat_flush_valid", out_valid, 0);

        // Asynchronous reset mid-stream.
        offer(32'h500, 1);
        step();
        in_valid = 1'b0;
        check("mid_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_stall", stall_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_bundle", e_now, 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        offer(32'h600, 1);
        step();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_pc", PCPlus4E, 32'h600);
        step();
        check("final_valid", out_valid, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID/EX pipeline stage for the 5-stage core with elastic valid/ready flow control, a 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It sits between decode/register-read and execute and carries the full decoded bundle: control bits, register specifiers, operands, immediate, shift amount and PC+4. It replaces the free-running ID/EX register, which had no reset, stall or flush capability.

## Interface
Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields
- REG_W, 5, width of rs/rt/rd/shamt fields
- ALUC_W, 4, width of ALU control field
- CNT_W, 16, width of stall counter

Ports (single clock domain; one clock, asynchronous active-low reset):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents a valid bundle
- in_ready  out  1  stage can accept a bundle this cycle
- flush  in  1  synchronous kill of all held bundles (branch/jump redirect)
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, LinkD  in  1 each  control bits
- ALUControlD  in  ALUC_W  ALU op
- RsD, RtD, RdD, ShamtD  in  REG_W each  specifiers / shift amount
- ReadData1D, ReadData2D, SignImmD, PCPlus4D  in  DATA_W each  operands, immediate, PC+4
- out_valid  out  1  execute-side bundle valid
- out_ready  in  1  execute consumes the bundle this cycle
- RegWriteE … PCPlus4E  out  same widths as D-side  registered bundle
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready

## Operation
- Storage: main register M (drives E outputs, out_valid = M.valid) and skid register S (S.valid internal).
- in_ready = !S.valid, taken from a flop; no combinational path from out_ready to in_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Priority per cycle: reset > flush > normal update.
- Normal update:
  - If M is empty or Drain: M loads S when S.valid (S empties); otherwise M loads the accepted bundle.
  - If S was moved into M and Accept: the new bundle goes into S.
  - If M is full, not draining, and Accept: the bundle goes into S.
  - If nothing loads M and Drain: M.valid goes to 0.
- Flush: M.valid and S.valid go to 0 at the next edge. A bundle offered in the same cycle is discarded, even though in_ready = 1.
- Bubble gating:
  - RegWriteE, MemWriteE, MemtoRegE and LinkE output stored value AND out_valid, so an invalid slot can never write the register file or memory.
  - The other E fields hold their last loaded value.
- stall_cnt increments when out_valid && !out_ready, saturates at 2^CNT_W−1, is unaffected by flush and is cleared only by reset.
- Ordering: bundles leave in acceptance order. No duplication or loss except through flush.

## Timing
- Reset (rst_n low, asynchronous): every register in M and S, all E outputs, out_valid, S.valid and stall_cnt are 0; in_ready = 1. The first accept can occur on the first edge with rst_n high.
- Latency: a bundle accepted at edge n is on the E outputs with out_valid = 1 after edge n. Zero-bubble throughput is 1 bundle per cycle while out_ready = 1.
- Backpressure: if out_ready drops, the bundle accepted in that cycle is captured in S and in_ready falls after that edge. At most 2 bundles are ever held.
- When out_ready returns: S moves to M on the draining edge and in_ready rises after that edge.
- Flush with out_ready = 1 in the same cycle: M is consumed by execute and nothing is retained.
- Reset asserted mid-stream: held bundles are lost immediately. No gating against clk is needed.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> all E outputs 0, out_valid = 0, in_ready = 1, stall_cnt = 0. Release rst_n -> the first bundle appears one cycle later.
- Streaming: feed 8 bundles, PCPlus4D = 4, 8 … 32, with out_ready = 1 -> PCPlus4E sequence 4 … 32 on 8 consecutive cycles, 1-cycle latency.
- Backpressure: bundles A (PC+4 = 0x100) and B (0x104) back-to-back, out_ready = 0 for 3 cycles -> A held on E, in_ready = 0 after B is captured, stall_cnt = 3. Release -> A then B, in_ready = 1 again.
- Flush: 2 bundles held (M and S full), pulse flush with in_valid = 1 and RegWriteD = 1 -> next cycle out_valid = 0, RegWriteE = MemWriteE = 0, in_ready = 1, the offered bundle never appears.
- Bubble gating: out_valid = 0 while the stored RegWrite = 1 -> RegWriteE = 0. Datapath fields keep their last values.
- Counter saturation with CNT_W = 4: stall for 20 cycles -> stall_cnt stops at 15. Flush -> stays 15. Reset -> 0.
